dds_key_ctrl: RTL

- Synchronous, debounced successor to the DDS key encoder.
- Converts five active-low push-buttons into DDS control words: waveform select, frequency tuning word, amplitude index and phase offset.
- All state is clocked on clk, with no key-as-clock paths. Parameters set the widths, step sizes and limits.
- Adds a direction key (up/down) and hold-to-auto-repeat for the frequency, amplitude and phase keys. Outputs feed the phase accumulator, ROM address offset and amplitude scaler directly.

---
 rtl/dds_key_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/dds_key_ctrl.sv
// Debounced five-key controller producing DDS waveform, frequency, amplitude and phase words.
// Frequency, amplitude and phase keys auto-repeat while held; a direction key selects up/down stepping.
module dds_key_ctrl #(
    parameter int unsigned FW           = 21,
    parameter int unsigned F_STEP       = 8590,
    parameter int unsigned F_MAX        = 1717987,
    parameter int unsigned AW           = 4,
    parameter int unsigned A_MIN        = 1,
    parameter int unsigned A_MAX        = 10,
    parameter int unsigned PW           = 9,
    parameter int unsigned P_STEP       = 100,
    parameter int unsigned NUM_WAVE     = 4,
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned HOLD_CYC     = 25000000,
    parameter int unsigned REPEAT_CYC   = 5000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_waveform_key,
    input  logic          set_f_key,
    input  logic          set_a_key,
    input  logic          set_p_key,
    input  logic          dir_key,
    output logic [1:0]    set_waveform,
    output logic [FW-1:0] f_control,
    output logic [AW-1:0] a_control,
    output logic [PW-1:0] p_control,
    output logic          dir,
    output logic          upd
);

    localparam int unsigned NK      = 5;
    localparam int unsigned NR      = 3;
    localparam int unsigned K_WAVE  = 0;
    localparam int unsigned K_F     = 1;
    localparam int unsigned K_P     = 3;
    localparam int unsigned K_DIR   = 4;
    localparam int unsigned FW1     = FW + 1;
    localparam int unsigned DBW     = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned RPT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int unsigned RCW     = $clog2(RPT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } rpt_state_t;

    logic [NK-1:0]  key_raw;
    logic [NK-1:0]  sync1_q;
    logic [NK-1:0]  sync2_q;
    logic [NK-1:0]  deb_q;
    logic [NK-1:0]  deb_d1_q;
    logic [DBW-1:0] db_cnt_q [NK];
    logic [NK-1:0]  press_c;
    logic [NR-1:0]  rpt_press_c;
    logic [NR-1:0]  rpt_rel_c;

    rpt_state_t     state_q   [NR];
    rpt_state_t     state_d   [NR];
    logic [RCW-1:0] rpt_cnt_q [NR];
    logic [RCW-1:0] rpt_cnt_d [NR];
    logic [NR-1:0]  step_c;

    logic [FW1-1:0] f_sum;
    logic [FW-1:0]  f_up, f_dn;
    logic [AW-1:0]  a_up, a_dn;
    logic [PW-1:0]  p_up, p_dn;
    logic [1:0]     wave_d;
    logic [FW-1:0]  f_d;
    logic [AW-1:0]  a_d;
    logic [PW-1:0]  p_d;
    logic           dir_d;
    logic           upd_d;

    assign key_raw = {dir_key, set_p_key, set_a_key, set_f_key, set_waveform_key};

    // Two-flop synchroniser and per-key debounce counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            deb_q    <= '1;
            deb_d1_q <= '1;
            for (int i = 0; i < NK; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q  <= key_raw;
            sync2_q  <= sync1_q;
            deb_d1_q <= deb_q;
            for (int i = 0; i < NK; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DBW'(DEBOUNCE_CYC)) begin
                    deb_q[i]    <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    assign press_c     = deb_d1_q & ~deb_q;
    assign rpt_press_c = press_c[K_P:K_F];
    assign rpt_rel_c   = ~deb_d1_q[K_P:K_F] & deb_q[K_P:K_F];

    // Repeat FSM state register (f, a, p)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NR; r++) begin
                state_q[r]   <= ST_IDLE;
                rpt_cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NR; r++) begin
                state_q[r]   <= state_d[r];
                rpt_cnt_q[r] <= rpt_cnt_d[r];
            end
        end
    end

    // Repeat FSM next state; release wins over a step due in the same cycle
    always_comb begin
        for (int r = 0; r < NR; r++) begin
            state_d[r]   = state_q[r];
            rpt_cnt_d[r] = rpt_cnt_q[r];
            case (state_q[r])
                ST_IDLE: begin
                    if (rpt_press_c[r]) begin
                        state_d[r]   = ST_HOLD;
                        rpt_cnt_d[r] = '0;
                    end
                end
                ST_HOLD: begin
                    if (rpt_rel_c[r]) begin
                        state_d[r] = ST_IDLE;
                    end else if (rpt_cnt_q[r] == RCW'(HOLD_CYC - 1)) begin
                        state_d[r]   = ST_REPEAT;
                        rpt_cnt_d[r] = '0;
                    end else begin
                        rpt_cnt_d[r] = rpt_cnt_q[r] + RCW'(1);
                    end
                end
                ST_REPEAT: begin
                    if (rpt_rel_c[r]) begin
                        state_d[r] = ST_IDLE;
                    end else if (rpt_cnt_q[r] == RCW'(REPEAT_CYC - 1)) begin
                        rpt_cnt_d[r] = '0;
                    end else begin
                        rpt_cnt_d[r] = rpt_cnt_q[r] + RCW'(1);
                    end
                end
                default: state_d[r] = ST_IDLE;
            endcase
        end
    end

    // Repeat FSM outputs: one step request per key
    always_comb begin
        step_c = '0;
        for (int r = 0; r < NR; r++) begin
            case (state_q[r])
                ST_IDLE:   step_c[r] = rpt_press_c[r];
                ST_HOLD:   step_c[r] = !rpt_rel_c[r] && (rpt_cnt_q[r] == RCW'(HOLD_CYC - 1));
                ST_REPEAT: step_c[r] = !rpt_rel_c[r] && (rpt_cnt_q[r] == RCW'(REPEAT_CYC - 1));
                default:   step_c[r] = 1'b0;
            endcase
        end
    end

    // Step arithmetic; frequency compares at one extra bit to catch overflow
    assign f_sum = {1'b0, f_control} + FW1'(F_STEP);
    assign f_up  = (f_sum > FW1'(F_MAX)) ? '0 : f_sum[FW-1:0];
    assign f_dn  = ({1'b0, f_control} < FW1'(F_STEP)) ? FW'(F_MAX) : f_control - FW'(F_STEP);
    assign a_up  = (a_control == AW'(A_MAX)) ? AW'(A_MIN) : a_control + AW'(1);
    assign a_dn  = (a_control == AW'(A_MIN)) ? AW'(A_MAX) : a_control - AW'(1);
    assign p_up  = p_control + PW'(P_STEP);
    assign p_dn  = p_control - PW'(P_STEP);

    always_comb begin
        wave_d = set_waveform;
        f_d    = f_control;
        a_d    = a_control;
        p_d    = p_control;
        dir_d  = dir;
        if (press_c[K_WAVE]) begin
            wave_d = (set_waveform == 2'(NUM_WAVE - 1)) ? 2'd0 : set_waveform + 2'd1;
        end
        if (step_c[0]) f_d = dir ? f_dn : f_up;
        if (step_c[1]) a_d = dir ? a_dn : a_up;
        if (step_c[2]) p_d = dir ? p_dn : p_up;
        if (press_c[K_DIR]) dir_d = ~dir;
        upd_d = (wave_d != set_waveform) || (f_d != f_control) || (a_d != a_control)
             || (p_d != p_control) || (dir_d != dir);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            set_waveform <= '0;
            f_control    <= FW'(F_STEP);
            a_control    <= AW'(A_MIN);
            p_control    <= '0;
            dir          <= 1'b0;
            upd          <= 1'b0;
        end else begin
            set_waveform <= wave_d;
            f_control    <= f_d;
            a_control    <= a_d;
            p_control    <= p_d;
            dir          <= dir_d;
            upd          <= upd_d;
        end
    end

endmodule
